// File: rtl/ifu_pkg.sv
// Shared instruction-fetch types: cache<->memory fill request/response and fill FSM states.
package ifu_pkg;

    localparam int unsigned I_LINE_WORDS = 4;

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic         valid;
        logic [31:0]  address;
        logic [127:0] filled_instruction;
    } t_i_mem2cache_rsp;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } t_fill_state;

endpackage

// File: rtl/i_mem_fill_pend_q.sv
// One-entry pending request buffer; push and pop in the same cycle replace the entry.
module i_mem_fill_pend_q (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_line,
    output logic        full,
    output logic [31:0] head
);

    logic        full_q, full_d;
    logic [31:0] head_q, head_d;

    always_comb begin
        full_d = push | (full_q & ~pop);
        head_d = push ? push_line : head_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            head_q <= '0;
        end else begin
            full_q <= full_d;
            head_q <= head_d;
        end
    end

    assign full = full_q;
    assign head = head_q;

endmodule

// File: rtl/i_mem_fill_ctrl.sv
// Instruction-cache line fill controller: four SRAM word reads per line, one response per fill.
// Define I_MEM_FILL_CWF_EN for critical-word-first issue order and the crit_word outputs.
module i_mem_fill_ctrl
    import ifu_pkg::*;
#(
    parameter int unsigned MEM_RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  t_cache2i_mem_req cache2i_mem_req,
    output logic             mem_rd_en,
    output logic [31:0]      mem_rd_addr,
    input  logic [31:0]      mem_rd_data,
    output t_i_mem2cache_rsp i_mem2cache_rsp,
    output logic             fill_busy
`ifdef I_MEM_FILL_CWF_EN
    ,
    output logic             crit_word_valid,
    output logic [31:0]      crit_word
`endif
);

    localparam logic [1:0] LAST_WORD = 2'(I_LINE_WORDS - 1);

    t_fill_state      state_q, state_d;
    logic [1:0]       issue_cnt_q, issue_cnt_d;
    logic [1:0]       ret_cnt_q, ret_cnt_d;
    logic [31:0]      infl_addr_q, infl_addr_d;
    logic [127:0]     line_buf_q, line_buf_d;
    t_i_mem2cache_rsp rsp_q, rsp_d;
    logic             prev_rsp_q, prev_rsp_d;

    logic [MEM_RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
    logic [MEM_RD_LATENCY:0]   rd_pipe_ext;
    logic                      beat_vld;

    logic [1:0]  word_ofs, issue_word, ret_word;
    logic        pend_push, pend_pop, pend_full;
    logic [31:0] pend_head;
    logic        hit_infl, hit_pend, hit_prev, req_ok;

`ifdef I_MEM_FILL_CWF_EN
    assign word_ofs = infl_addr_q[3:2];
`else
    assign word_ofs = 2'd0;
`endif

    assign issue_word = issue_cnt_q + word_ofs;
    assign ret_word   = ret_cnt_q + word_ofs;

    // Read strobe delayed by the SRAM latency marks which cycles carry a returning beat.
    assign rd_pipe_ext = {rd_pipe_q, mem_rd_en};
    assign rd_pipe_d   = rd_pipe_ext[MEM_RD_LATENCY-1:0];
    assign beat_vld    = rd_pipe_ext[MEM_RD_LATENCY];

    always_comb begin
        mem_rd_en   = (state_q == ISSUE);
        mem_rd_addr = '0;
        if (mem_rd_en) begin
            mem_rd_addr = {infl_addr_q[31:4], issue_word, 2'b00};
        end
    end

    // In RESP the pending head becomes the in-flight line, so hit_pend still filters duplicates.
    always_comb begin
        hit_infl = (state_q != IDLE) && (cache2i_mem_req.address[31:4] == infl_addr_q[31:4]);
        hit_pend = pend_full && (cache2i_mem_req.address[31:4] == pend_head[31:4]);
        hit_prev = prev_rsp_q && (cache2i_mem_req.address[31:4] == rsp_q.address[31:4]);
        req_ok   = cache2i_mem_req.valid && !hit_infl && !hit_pend && !hit_prev;
    end

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        infl_addr_d = infl_addr_q;
        line_buf_d  = line_buf_q;
        rsp_d       = rsp_q;
        rsp_d.valid = 1'b0;
        prev_rsp_d  = rsp_q.valid;
        pend_push   = 1'b0;
        pend_pop    = 1'b0;

        if (beat_vld) begin
            line_buf_d[{ret_word, 5'd0} +: 32] = mem_rd_data;
            ret_cnt_d = ret_cnt_q + 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (req_ok) begin
                    state_d     = ISSUE;
                    infl_addr_d = cache2i_mem_req.address;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            ISSUE: begin
                issue_cnt_d = issue_cnt_q + 2'd1;
                pend_push   = req_ok && !pend_full;
                if (issue_cnt_q == LAST_WORD) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                pend_push = req_ok && !pend_full;
                if (beat_vld && (ret_cnt_q == LAST_WORD)) begin
                    state_d                  = RESP;
                    rsp_d.valid              = 1'b1;
                    rsp_d.address            = infl_addr_q;
                    rsp_d.filled_instruction = line_buf_d;
                end
            end
            RESP: begin
                // Buffer is treated as drained this cycle: a new request may refill it or start directly.
                if (pend_full) begin
                    pend_pop    = 1'b1;
                    pend_push   = req_ok;
                    infl_addr_d = pend_head;
                    state_d     = ISSUE;
                end else if (req_ok) begin
                    infl_addr_d = cache2i_mem_req.address;
                    state_d     = ISSUE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            infl_addr_q <= '0;
            line_buf_q  <= '0;
            rsp_q       <= '0;
            prev_rsp_q  <= 1'b0;
            rd_pipe_q   <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            infl_addr_q <= infl_addr_d;
            line_buf_q  <= line_buf_d;
            rsp_q       <= rsp_d;
            prev_rsp_q  <= prev_rsp_d;
            rd_pipe_q   <= rd_pipe_d;
        end
    end

    i_mem_fill_pend_q u_pend_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pend_push),
        .pop       (pend_pop),
        .push_line (cache2i_mem_req.address),
        .full      (pend_full),
        .head      (pend_head)
    );

    assign i_mem2cache_rsp = rsp_q;
    assign fill_busy       = (state_q != IDLE) | pend_full;

`ifdef I_MEM_FILL_CWF_EN
    logic        crit_vld_q, crit_vld_d;
    logic [31:0] crit_word_q, crit_word_d;

    always_comb begin
        crit_vld_d  = beat_vld && (ret_cnt_q == 2'd0);
        crit_word_d = crit_vld_d ? mem_rd_data : crit_word_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crit_vld_q  <= 1'b0;
            crit_word_q <= '0;
        end else begin
            crit_vld_q  <= crit_vld_d;
            crit_word_q <= crit_word_d;
        end
    end

    assign crit_word_valid = crit_vld_q;
    assign crit_word       = crit_word_q;
`endif

endmodule
